// File: rtl/ram_io_responder.sv
// Byte-wide RAM port responder: synchronous main RAM plus a small memory-mapped
// I/O window (TX FIFO, RX holding byte, status, halt, cycle counter), 1-cycle read latency.
module ram_io_responder #(
  parameter int unsigned RAM_AW     = 17,
  parameter int unsigned TX_DEPTH   = 8,
  parameter logic [1:0]  IO_BASE_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ram_rw,
  input  logic [31:0] ram_addr,
  input  logic [7:0]  ram_w_data,
  output logic [7:0]  ram_r_data,
  output logic        io_full,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid,
  output logic        io_rx_ready,
  output logic        sim_halt
);

  localparam int unsigned PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(TX_DEPTH);
  localparam logic [CW-1:0] DEPTH_M1_C = CW'(TX_DEPTH - 1);

  logic [7:0]        mem_q [0:(1<<RAM_AW)-1];
  logic [7:0]        mem_rd_q;
  logic [7:0]        tx_mem_q [0:TX_DEPTH-1];

  logic              rd_ram_q, rd_ram_d;
  logic [7:0]        io_rd_q, io_rd_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              rx_held_q, rx_held_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic              halt_q, halt_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [31:0]       snap_q, snap_d;

  logic              io_sel;
  logic [3:0]        io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              push, pop, push_ok;
  logic              addr_unused_s;

  assign io_sel  = (ram_addr[17:16] == IO_BASE_HI);
  assign io_off  = ram_addr[3:0];
  assign ram_idx = ram_addr[RAM_AW-1:0];
  assign addr_unused_s = ^{ram_addr[31:RAM_AW], snap_q[7:0]};

  assign io_tx_valid = (count_q != {CW{1'b0}});
  assign io_tx_data  = tx_mem_q[rd_ptr_q];
  assign pop         = io_tx_valid && io_tx_ready;
  assign push        = io_sel && ram_rw && (io_off == 4'h0);
  // At full a push still fits when the head leaves in the same cycle.
  assign push_ok     = push && ((count_q < DEPTH_C) || pop);

  assign ram_r_data  = rd_ram_q ? mem_rd_q : io_rd_q;
  assign io_full     = full_q;
  assign io_rx_ready = !rx_held_q;
  assign sim_halt    = halt_q;

  always_comb begin
    rd_ram_d  = rd_ram_q;
    io_rd_d   = io_rd_q;
    rx_held_d = rx_held_q;
    rx_byte_d = rx_byte_q;
    halt_d    = halt_q;
    snap_d    = snap_q;
    if (!io_sel) begin
      if (!ram_rw) begin
        rd_ram_d = 1'b1;
      end else begin
        rd_ram_d = rd_ram_q;
      end
    end else if (!ram_rw) begin
      rd_ram_d = 1'b0;
      case (io_off)
        4'h0: begin
          io_rd_d   = rx_held_q ? rx_byte_q : 8'h00;
          rx_held_d = 1'b0;
        end
        4'h4: io_rd_d = {5'b00000, ovf_q, rx_held_q, (count_q == DEPTH_C)};
        4'h8: begin
          snap_d  = cyc_q;
          io_rd_d = cyc_q[7:0];
        end
        4'h9:    io_rd_d = snap_q[15:8];
        4'hA:    io_rd_d = snap_q[23:16];
        4'hB:    io_rd_d = snap_q[31:24];
        default: io_rd_d = 8'h00;
      endcase
    end else begin
      case (io_off)
        4'h4:    halt_d = 1'b1;
        default: halt_d = halt_q;
      endcase
    end
    // Arrival only when empty; a consume needs a held byte, so the two never overlap.
    if (io_rx_valid && !rx_held_q) begin
      rx_held_d = 1'b1;
      rx_byte_d = io_rx_data;
    end else begin
      rx_byte_d = rx_byte_q;
    end
  end

  always_comb begin
    wr_ptr_d = push_ok ? (wr_ptr_q + {{(PW-1){1'b0}}, 1'b1}) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + {{(PW-1){1'b0}}, 1'b1}) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    ovf_d  = ovf_q || (push && !push_ok);
    full_d = (count_d >= DEPTH_M1_C);
    cyc_d  = cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ram_q  <= 1'b0;
      io_rd_q   <= 8'h00;
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rx_held_q <= 1'b0;
      rx_byte_q <= 8'h00;
      halt_q    <= 1'b0;
      cyc_q     <= 32'd0;
      snap_q    <= 32'd0;
    end else if (rdy) begin
      rd_ram_q  <= rd_ram_d;
      io_rd_q   <= io_rd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      rx_held_q <= rx_held_d;
      rx_byte_q <= rx_byte_d;
      halt_q    <= halt_d;
      cyc_q     <= cyc_d;
      snap_q    <= snap_d;
    end
  end

  // Storage arrays carry no reset so they map onto RAM macros.
  always_ff @(posedge clk) begin
    if (rst && rdy && !io_sel) begin
      if (ram_rw) begin
        mem_q[ram_idx] <= ram_w_data;
      end else begin
        mem_rd_q <= mem_q[ram_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && rdy && push_ok) begin
      tx_mem_q[wr_ptr_q] <= ram_w_data;
    end
  end

endmodule

// File: doc/ram_io_responder.md
Name: ram_io_responder

Overview:
- Responder end of the byte-wide RAM port driven by the CPU memory controller.
- Decodes each cycle's address into one of two regions:
  - main RAM, synchronous byte array;
  - memory-mapped I/O window: TX FIFO, RX holding byte, status, halt, cycle counter.
- Returns read data with exactly one cycle of latency, which is the timing the controller's byte-sequencing counter relies on.

Parameters:
- RAM_AW, 17, RAM byte-address width; depth 2^RAM_AW bytes.
- TX_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- IO_BASE_HI, 2'b11, value of addr[17:16] that selects the I/O window.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- rdy  in  1  global enable; when low, all state is frozen
- ram_rw  in  1  1 = write, 0 = read
- ram_addr  in  32  byte address
- ram_w_data  in  8  write byte
- ram_r_data  out  8  registered read byte
- io_full  out  1  back-pressure: TX FIFO has at most 1 free entry
- io_tx_data  out  8  head byte of TX FIFO
- io_tx_valid  out  1  TX FIFO non-empty
- io_tx_ready  in  1  downstream accepts the head byte
- io_rx_data  in  8  incoming byte
- io_rx_valid  in  1  incoming byte valid
- io_rx_ready  out  1  RX holding register empty
- sim_halt  out  1  sticky halt request

Behaviour:
- Reset: applied when rst==0 at a clk edge, regardless of rdy.
  - ram_r_data=0, io_tx_valid=0, io_full=0, io_rx_ready=1, sim_halt=0.
  - TX FIFO pointers and count, RX holding register, overflow flag and cycle counter all cleared.
  - RAM contents are not cleared.
  - Reset mid-transfer discards any in-flight read data and all FIFO contents.
- rdy==0: nothing updates, including the counter, FIFO, RX and ram_r_data. Outputs hold.
- Decode: io_sel = (ram_addr[17:16]==IO_BASE_HI); otherwise RAM index = ram_addr[RAM_AW-1:0].
- RAM write: io_sel==0 && ram_rw==1 → mem[index] <= ram_w_data at the edge.
- RAM read: io_sel==0 && ram_rw==0 → ram_r_data <= mem[index] at the edge.
  - Data is valid during the cycle after the address was presented.
  - A write and a read to the same address are never concurrent, since there is one port per cycle.
- I/O register map; the offset is ram_addr[3:0], and unlisted offsets read 0 and ignore writes:
  - 0x0 write: push ram_w_data into TX FIFO.
  - 0x0 read: ram_r_data <= RX byte if held, else 0; consumes the RX byte.
  - 0x4 read: ram_r_data <= {5'b0, overflow, rx_held, tx_full}.
  - 0x4 write: sim_halt <= 1 (sticky until reset).
  - 0x8..0xB read: bytes 0..3 (little-endian) of the 32-bit counter snapshot. Reading 0x8 latches the live counter into the snapshot and returns its byte 0; 0x9..0xB return the snapshot.
- I/O reads also have 1-cycle latency. A side effect (RX consume, snapshot) occurs only on reads of those exact offsets.
- Each I/O read or write is treated as a one-cycle access. A write address held for N cycles pushes N bytes.
- Cycle counter: +1 on every rdy cycle; wraps 0xFFFFFFFF → 0.
- TX FIFO:
  - Push happens when count<TX_DEPTH, or when count==TX_DEPTH and a pop occurs in the same cycle.
  - A push at full with no pop is dropped and sets overflow (sticky until reset).
  - Pop when io_tx_valid && io_tx_ready.
  - Simultaneous push+pop leaves count unchanged.
  - Pointers wrap modulo TX_DEPTH.
  - io_full = (count >= TX_DEPTH-1), registered from the next-state count.
  - io_tx_data/io_tx_valid reflect the FIFO head combinationally from the registered state.
- RX holding register:
  - io_rx_ready = !rx_held.
  - Captures io_rx_data when io_rx_valid && io_rx_ready.
  - A consume and an arrival in the same cycle: the consume wins; the new byte is not accepted because ready was low.

Test Plan:
- Write 0xA5 to 0x00001234, then read 0x00001234 → ram_r_data==0xA5 exactly one cycle after the read address; 0x00 at the read cycle itself if the previous value was 0.
- Write 0x41,0x42,0x43 to 0x30000 with io_tx_ready=0 → io_tx_valid=1, io_tx_data=0x41. Raise io_tx_ready → 0x41,0x42,0x43 drain on consecutive cycles, then io_tx_valid=0.
- With TX_DEPTH=8 and io_tx_ready=0, push 7 bytes → io_full=1. The 9th push → dropped, and a read of 0x30004 returns 0x05 (overflow|tx_full, no rx byte). A push+pop at full keeps count at 8.
- Drive io_rx_data=0x7E with io_rx_valid → io_rx_ready drops. Read 0x30000 → 0x7E; then io_rx_ready=1. A second read returns 0x00.
- After reset, hold rdy=1 for 100 cycles, read 0x30008..0x3000B → little-endian snapshot equal to the cycle count at the 0x8 read. Hold rdy=0 for 10 cycles → the counter does not advance.
- Write any byte to 0x30004 → sim_halt=1 next cycle and stays 1. Assert rst=0 mid TX drain → all outputs take their reset values at that edge and the FIFO is empty.
